// File: rtl/sgpio_rx_param.sv
// Parametrised SGPIO target receiver: decodes NUM_DRV x (ACT, LOC, FAIL) per frame,
// validates frame length, stretches activity blinks and detects loss of SCLK.
module sgpio_rx_param #(
    parameter int NUM_DRV       = 36,
    parameter int TIMEOUT_CYC   = 50000,
    parameter int TICK_CYC      = 25000,
    parameter int STRETCH_TICKS = 2
) (
    input  logic               SYSCLK,
    input  logic               RESET_N,
    input  logic               SCLK,
    input  logic               SLOAD,
    input  logic               SDOUT,
    input  logic               ERR_CLR,
    output logic [NUM_DRV-1:0] ACT_LED_L,
    output logic [NUM_DRV-1:0] LOC,
    output logic [NUM_DRV-1:0] FAIL,
    output logic               LINK_OK,
    output logic               FRAME_STB,
    output logic [7:0]         ERR_CNT
);

    localparam int FRAME_BITS = 3 * NUM_DRV;
    localparam int BW  = $clog2(FRAME_BITS + 1);
    localparam int TOW = $clog2(TIMEOUT_CYC + 1);
    localparam int TKW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam logic [BW-1:0]  FB      = BW'(FRAME_BITS);
    localparam logic [TOW-1:0] TO_MAX  = TOW'(TIMEOUT_CYC);
    localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_CYC - 1);
    localparam logic [TKW-1:0] TK_LAST = TKW'(TICK_CYC - 1);
    localparam logic [3:0]     ST_LOAD = 4'(STRETCH_TICKS);

    logic [2:0]            sclk_sync;
    logic [1:0]            sload_sync;
    logic [1:0]            sdout_sync;
    logic                  vld_p0;
    logic                  sload_p0;
    logic                  sdout_p0;

    logic                  in_frame;
    logic [BW-1:0]         bit_cnt;
    logic [FRAME_BITS-1:0] payload;
    logic [NUM_DRV-1:0]    act_q;
    logic [TOW-1:0]        to_cnt;
    logic [TKW-1:0]        tick_cnt;
    logic [3:0]            str_cnt [NUM_DRV];

    logic                  boundary;
    logic                  commit;
    logic                  short_err;
    logic                  shift_en;
    logic                  timeout;
    logic                  tick;
    logic [NUM_DRV-1:0]    act_w;
    logic [NUM_DRV-1:0]    loc_w;
    logic [NUM_DRV-1:0]    fail_w;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Synchroniser stage; SLOAD/SDOUT get one extra flop so they line up with the SCLK edge
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sclk_sync  <= '0;
            sload_sync <= '0;
            sdout_sync <= '0;
            vld_p0     <= 1'b0;
            sload_p0   <= 1'b0;
            sdout_p0   <= 1'b0;
        end else begin
            sclk_sync  <= {sclk_sync[1:0], SCLK};
            sload_sync <= {sload_sync[0], SLOAD};
            sdout_sync <= {sdout_sync[0], SDOUT};
            vld_p0     <= sclk_sync[1] & ~sclk_sync[2];
            sload_p0   <= sload_sync[1];
            sdout_p0   <= sdout_sync[1];
        end
    end

    always_comb begin
        boundary  = vld_p0 & sload_p0;
        commit    = boundary & in_frame & (bit_cnt >= FB);
        short_err = boundary & in_frame & (bit_cnt < FB);
        shift_en  = vld_p0 & ~sload_p0 & in_frame & (bit_cnt < FB);
        timeout   = ~vld_p0 & (to_cnt == TO_LAST);
        tick      = (tick_cnt == TK_LAST);
        act_w     = '0;
        loc_w     = '0;
        fail_w    = '0;
        for (int i = 0; i < NUM_DRV; i++) begin
            act_w[i]  = payload[3*i];
            loc_w[i]  = payload[3*i+1];
            fail_w[i] = payload[3*i+2];
        end
    end

    // Frame assembly and commit stage
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            in_frame  <= 1'b0;
            bit_cnt   <= '0;
            payload   <= '0;
            act_q     <= '0;
            LOC       <= '0;
            FAIL      <= '0;
            LINK_OK   <= 1'b0;
            FRAME_STB <= 1'b0;
        end else begin
            FRAME_STB <= commit;
            if (timeout) begin
                in_frame <= 1'b0;
                bit_cnt  <= '0;
                act_q    <= '0;
                LOC      <= '0;
                FAIL     <= '0;
                LINK_OK  <= 1'b0;
            end else begin
                if (boundary) begin
                    in_frame <= 1'b1;
                    bit_cnt  <= '0;
                end else if (shift_en) begin
                    payload[bit_cnt] <= sdout_p0;
                    bit_cnt          <= bit_cnt + BW'(1);
                end
                if (commit) begin
                    act_q   <= act_w;
                    LOC     <= loc_w;
                    FAIL    <= fail_w;
                    LINK_OK <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            to_cnt   <= '0;
            tick_cnt <= '0;
            ERR_CNT  <= 8'd0;
        end else begin
            if (vld_p0)
                to_cnt <= '0;
            else if (to_cnt != TO_MAX)
                to_cnt <= to_cnt + TOW'(1);
            tick_cnt <= tick ? '0 : tick_cnt + TKW'(1);
            // A clear landing with an error still records that error
            if (short_err)
                ERR_CNT <= ERR_CLR ? 8'd1 : sat_inc8(ERR_CNT);
            else if (ERR_CLR)
                ERR_CNT <= 8'd0;
        end
    end

    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_DRV; i++) str_cnt[i] <= 4'd0;
        end else begin
            for (int i = 0; i < NUM_DRV; i++) begin
                if (timeout)
                    str_cnt[i] <= 4'd0;
                else if (commit && act_w[i])
                    str_cnt[i] <= ST_LOAD;
                else if (tick && str_cnt[i] != 4'd0)
                    str_cnt[i] <= str_cnt[i] - 4'd1;
            end
        end
    end

    always_comb begin
        ACT_LED_L = '1;
        for (int i = 0; i < NUM_DRV; i++)
            ACT_LED_L[i] = (STRETCH_TICKS == 0) ? ~act_q[i] : (str_cnt[i] == 4'd0);
    end

endmodule

// File: tb/tb_sgpio_rx_param.sv
// Scoreboard bench for sgpio_rx_param: 4 drives, SCLK = SYSCLK/8.
module tb_sgpio_rx_param;

    localparam int ND = 4;

    logic          SYSCLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          SCLK = 1'b0;
    logic          SLOAD = 1'b0;
    logic          SDOUT = 1'b0;
    logic          ERR_CLR = 1'b0;
    logic [ND-1:0] ACT_LED_L;
    logic [ND-1:0] LOC;
    logic [ND-1:0] FAIL;
    logic          LINK_OK;
    logic          FRAME_STB;
    logic [7:0]    ERR_CNT;

    typedef struct packed {
        logic [3:0] loc;
        logic [3:0] fail;
        logic [3:0] actl;
    } exp_t;

    exp_t q[$];
    exp_t last_exp;
    int   checks = 0;
    int   errors = 0;
    int   stb_seen = 0;
    int   stb_exp = 0;
    int   lit_run = 0;
    int   lit_len = 0;

    sgpio_rx_param #(
        .NUM_DRV(ND), .TIMEOUT_CYC(64), .TICK_CYC(8), .STRETCH_TICKS(2)
    ) dut (
        .SYSCLK(SYSCLK), .RESET_N(RESET_N), .SCLK(SCLK), .SLOAD(SLOAD),
        .SDOUT(SDOUT), .ERR_CLR(ERR_CLR), .ACT_LED_L(ACT_LED_L), .LOC(LOC),
        .FAIL(FAIL), .LINK_OK(LINK_OK), .FRAME_STB(FRAME_STB), .ERR_CNT(ERR_CNT)
    );

    always #5 SYSCLK = ~SYSCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [11:0] d);
        exp_t m;
        for (int i = 0; i < ND; i++) begin
            m.actl[i] = ~d[3*i];
            m.loc[i]  = d[3*i+1];
            m.fail[i] = d[3*i+2];
        end
        return m;
    endfunction

    // Scoreboard: every commit must match the oldest pending expectation
    always @(negedge SYSCLK) begin
        if (FRAME_STB) begin
            stb_seen++;
            if (q.size() == 0) begin
                check("unexpected_stb", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sb_loc", 32'(LOC), 32'(e.loc));
                check("sb_fail", 32'(FAIL), 32'(e.fail));
                check("sb_actl", 32'(ACT_LED_L), 32'(e.actl));
                check("sb_link", 32'(LINK_OK), 32'd1);
            end
        end
    end

    always @(negedge SYSCLK) begin
        if (!RESET_N) begin
            lit_run = 0;
        end else if (!ACT_LED_L[0]) begin
            lit_run++;
        end else if (lit_run != 0) begin
            lit_len = lit_run;
            lit_run = 0;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic sgpio_bit(input logic ld, input logic d);
        @(negedge SYSCLK);
        SCLK = 1'b0; SLOAD = ld; SDOUT = d;
        repeat (3) @(negedge SYSCLK);
        SCLK = 1'b1;
        repeat (4) @(negedge SYSCLK);
        SCLK = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) sgpio_bit(1'b0, d[i]);
    endtask

    task automatic close_good(input logic [11:0] d);
        last_exp = model(d);
        q.push_back(last_exp);
        stb_exp++;
        sgpio_bit(1'b1, 1'b0);
        repeat (8) @(negedge SYSCLK);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_actl"}, 32'(ACT_LED_L), 32'hF);
        check({tag, "_loc"}, 32'(LOC), 32'h0);
        check({tag, "_fail"}, 32'(FAIL), 32'h0);
        check({tag, "_link"}, 32'(LINK_OK), 32'h0);
        check({tag, "_stb"}, 32'(FRAME_STB), 32'h0);
        check({tag, "_err"}, 32'(ERR_CNT), 32'h0);
    endtask

    initial begin
        logic [11:0] d;
        repeat (3) @(negedge SYSCLK);
        check_reset_outputs("reset");
        RESET_N = 1'b1;
        repeat (3) @(negedge SYSCLK);

        // Good frame: drive0 ACT, drive2 LOC, drive3 FAIL
        sgpio_bit(1'b1, 1'b0);
        send_bits(32'h881, 12);
        close_good(12'h881);
        check("good_link", 32'(LINK_OK), 32'd1);
        check("good_loc", 32'(LOC), 32'h4);
        check("good_fail", 32'(FAIL), 32'h8);
        check("good_stb_cnt", 32'(stb_seen), 32'(stb_exp));
        check("good_err", 32'(ERR_CNT), 32'd0);

        // Stretch: next frame has drive0 ACT=0
        send_bits(32'h492, 12);
        close_good(12'h492);
        check("stretch_len_ok", 32'((lit_len >= 9) && (lit_len <= 16)), 32'd1);

        for (int k = 0; k < 3; k++) begin
            d = 12'($urandom);
            send_bits(32'(d), 12);
            close_good(d);
        end
        check("rand_stb_cnt", 32'(stb_seen), 32'(stb_exp));

        // Short frame
        send_bits(32'h55, 7);
        sgpio_bit(1'b1, 1'b0);
        repeat (8) @(negedge SYSCLK);
        check("short_err1", 32'(ERR_CNT), 32'd1);
        check("short_no_stb", 32'(stb_seen), 32'(stb_exp));
        check("short_loc_hold", 32'(LOC), 32'(last_exp.loc));
        check("short_fail_hold", 32'(FAIL), 32'(last_exp.fail));
        check("short_link_hold", 32'(LINK_OK), 32'd1);
        for (int k = 0; k < 255; k++) begin
            send_bits(32'h1, 1);
            sgpio_bit(1'b1, 1'b0);
        end
        repeat (8) @(negedge SYSCLK);
        check("err_sat", 32'(ERR_CNT), 32'd255);
        ERR_CLR = 1'b1;
        @(negedge SYSCLK);
        ERR_CLR = 1'b0;
        @(negedge SYSCLK);
        check("err_clr", 32'(ERR_CNT), 32'd0);

        // Long frame: only the first 12 bits count
        d = 12'h3A5;
        send_bits({12'h0, 8'hFF, d}, 20);
        close_good(d);
        check("long_err", 32'(ERR_CNT), 32'd0);
        check("long_stb_cnt", 32'(stb_seen), 32'(stb_exp));

        // Timeout: SCLK idle
        repeat (30) @(negedge SYSCLK);
        check("pre_timeout_link", 32'(LINK_OK), 32'd1);
        repeat (70) @(negedge SYSCLK);
        check("to_link", 32'(LINK_OK), 32'd0);
        check("to_loc", 32'(LOC), 32'd0);
        check("to_fail", 32'(FAIL), 32'd0);
        check("to_actl", 32'(ACT_LED_L), 32'hF);
        sgpio_bit(1'b1, 1'b0);
        repeat (6) @(negedge SYSCLK);
        check("restart_no_err", 32'(ERR_CNT), 32'd0);
        d = 12'hC36;
        send_bits(32'(d), 12);
        close_good(d);
        check("restart_link", 32'(LINK_OK), 32'd1);
        check("restart_stb_cnt", 32'(stb_seen), 32'(stb_exp));

        // Reset mid-frame
        send_bits(32'h1F, 5);
        @(negedge SYSCLK);
        RESET_N = 1'b0;
        repeat (2) @(negedge SYSCLK);
        check_reset_outputs("midrst");
        RESET_N = 1'b1;
        repeat (3) @(negedge SYSCLK);
        sgpio_bit(1'b1, 1'b0);
        d = 12'h5A9;
        send_bits(32'(d), 12);
        close_good(d);
        check("post_rst_err", 32'(ERR_CNT), 32'd0);
        check("post_rst_link", 32'(LINK_OK), 32'd1);
        check("post_rst_loc", 32'(LOC), 32'(model(d).loc));

        repeat (10) @(negedge SYSCLK);
        check("final_stb_cnt", 32'(stb_seen), 32'(stb_exp));
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sgpio_rx_param.md
# sgpio_rx_param

Parametrised SGPIO target receiver for the Status CPLD, the successor to the fixed 36-drive activity-only SGPIO decoder. It samples one SGPIO bus (SCLK/SLOAD/SDOUT) in the SYSCLK domain and decodes NUM_DRV drives × 3 bits (activity, locate, fail). It also validates frame length, stretches activity pulses into visible LED blinks, and detects loss of the SGPIO clock. Two instances feed the drive LED cathode outputs and the fault LED logic in TOP.

## Interface
- NUM_DRV, 36: drives on this bus; frame payload FRAME_BITS = 3·NUM_DRV.
- TIMEOUT_CYC, 50000: SYSCLK cycles with no SCLK rising edge before the link is declared lost.
- TICK_CYC, 25000: period in SYSCLK cycles of the shared stretch tick.
- STRETCH_TICKS, 2: ticks an ACT LED stays lit after the last frame with ACT=1 (0..15; 0 = no stretch).
- SYSCLK  in  1  system clock, ≥ 4× SCLK frequency.
- RESET_N  in  1  reset, asynchronous, active-low.
- SCLK, SLOAD, SDOUT  in  1 each  SGPIO bus, asynchronous to SYSCLK.
- ERR_CLR  in  1  synchronous pulse, clears ERR_CNT.
- ACT_LED_L  out  NUM_DRV  activity LED cathode drive, active-low.
- LOC  out  NUM_DRV  committed locate bits, active-high.
- FAIL  out  NUM_DRV  committed fail bits, active-high.
- LINK_OK  out  1  a valid frame has been committed and no timeout has occurred since.
- FRAME_STB  out  1  one-cycle pulse on each frame commit.
- ERR_CNT  out  8  count of short frames, saturating.

## Operation
- SCLK, SLOAD and SDOUT each pass through a 2-flop synchroniser. SCLK rise = sync2 & ~sync3; this single-cycle event is "edge".
- Bit order: drive i uses bit 3i = ACT, 3i+1 = LOC, 3i+2 = FAIL. Drive 0 is shifted in first.
- Edge with SLOAD=1 marks a frame boundary:
  - If in_frame=1 and bit_cnt ≥ FRAME_BITS, commit the first FRAME_BITS bits to LOC/FAIL/ACT, pulse FRAME_STB, set LINK_OK=1.
  - If in_frame=1 and bit_cnt < FRAME_BITS, discard the frame and increment ERR_CNT.
  - Then set in_frame=1 and bit_cnt=0. SDOUT sampled on the SLOAD edge is discarded.
- Edge with SLOAD=0 and in_frame=1: shift SDOUT into position bit_cnt if bit_cnt < FRAME_BITS. bit_cnt saturates at FRAME_BITS; extra vendor bits are ignored.
- Edges with in_frame=0 are ignored.
- Stretch (one 4-bit counter per drive):
  - On commit with ACT_i=1, load STRETCH_TICKS; on tick, decrement if nonzero.
  - ACT_LED_L[i] = 0 while the counter ≠ 0.
  - With STRETCH_TICKS=0, ACT_LED_L[i] = ~committed ACT_i.
- Tick counter: free-running 0..TICK_CYC-1; tick fires on wrap.
- Timeout:
  - A counter is cleared on every edge and saturates. On reaching TIMEOUT_CYC, the block sets LINK_OK=0, LOC=0, FAIL=0, clears all stretch counters (ACT_LED_L all 1), and sets in_frame=0, bit_cnt=0.
  - The next SLOAD edge starts a fresh frame. ERR_CNT is unaffected.
- ERR_CNT saturates at 255. ERR_CLR clears it to 0. ERR_CLR coinciding with an error increment gives 1.

## Timing
- Reset values: ACT_LED_L all 1; LOC and FAIL 0; LINK_OK 0; FRAME_STB 0; ERR_CNT 0; in_frame 0; all counters 0.
- Edge is asserted 3 SYSCLK cycles after the SCLK rise is first sampled.
- Commit registers and FRAME_STB update on the SYSCLK edge that ends the edge cycle, giving a fixed 4-cycle latency from SCLK sampling to outputs.
- A tick in the same cycle as a commit: the load wins over the decrement.
- A timeout in the same cycle as an edge cannot occur, because an edge clears the timeout counter first.
- RESET_N assertion mid-frame returns every register to its reset value asynchronously. The partial frame is lost and is not counted as an error.
- LINK_OK rises together with the first FRAME_STB.

## Test plan
- Bench setup for all scenarios: NUM_DRV=4, TICK_CYC=8, STRETCH_TICKS=2, TIMEOUT_CYC=64, SCLK = SYSCLK/8.
- Good frame: SLOAD, 12 bits 001_000_010_100 (drive 0 first = ACT), then SLOAD -> FRAME_STB pulse, LINK_OK=1, LOC=4'b0100, FAIL=4'b1000, ACT_LED_L=4'b1110.
- Stretch: one frame with drive 0 ACT=1, then frames with ACT=0 -> ACT_LED_L[0] stays 0 until 2 ticks after the commit, then returns to 1 (lit 9..16 SYSCLK cycles).
- Short frame: SLOAD, 7 bits, SLOAD -> no FRAME_STB, outputs unchanged, ERR_CNT=1. After 256 short frames ERR_CNT=255. ERR_CLR -> 0.
- Long frame: 20 bits between SLOADs -> commit uses the first 12 bits, ERR_CNT unchanged.
- Timeout: stop SCLK for 64 SYSCLK cycles -> LINK_OK=0, LOC=FAIL=0, ACT_LED_L=4'hF. On restart, the first SLOAD produces no error and the second SLOAD commits.
- Reset mid-frame after 5 bits -> all outputs return to reset values. The next full frame commits normally and ERR_CNT=0.
